// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional writeback bypass and a
// per-register busy scoreboard; x0 reads as zero and is never busy.
module register_file_mp #(
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]  rs_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rs_data_o,
    output logic [NUM_READ-1:0]              rs_busy_o,
    input  logic [NUM_WRITE-1:0]             wr_en_i,
    input  logic [NUM_WRITE*$clog2(NUM_REGS)-1:0] wr_addr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data_i,
    input  logic                             issue_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]      issue_addr_i,
    input  logic                             flush_i
);

    localparam int AW = $clog2(NUM_REGS);

    logic [AW-1:0]         wr_addr [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wr_data [NUM_WRITE];
    logic [NUM_WRITE-1:0]  wr_eff;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;

    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
        assign wr_addr[j] = wr_addr_i[j*AW +: AW];
        assign wr_data[j] = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
        assign wr_eff[j]  = wr_en_i[j] && (wr_addr_i[j*AW +: AW] != '0);
    end

    // Ascending port order lets the highest-index port override on conflicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_eff[j]) begin
                    regs[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    // Writes clear, issue sets over a same-cycle write, flush overrides both.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr_eff[j]) begin
                busy_nxt[wr_addr[j]] = 1'b0;
            end
        end
        if (issue_en_i && (issue_addr_i != '0)) begin
            busy_nxt[issue_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0]         addr;
        logic                  hit;
        logic [DATA_WIDTH-1:0] fwd;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign addr = rs_addr_i[k*AW +: AW];

        always_comb begin
            hit = 1'b0;
            fwd = '0;
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_eff[j] && (wr_addr[j] == addr)) begin
                    hit = 1'b1;
                    fwd = wr_data[j];
                end
            end
        end

        // Outputs are forced to zero during reset so a bypassed write cannot leak out.
        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if ((BYPASS != 0) && hit) begin
                data = fwd;
                bsy  = 1'b0;
            end
            if (!rst_n || (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rs_busy_o[k] = bsy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one non-bypassing
// instance share stimulus and are checked against hand-computed tables.
module tb_register_file_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data_b, rs_data_n;
    logic [1:0]  rs_busy_b, rs_busy_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;

    int total = 0;
    int bad   = 0;

    register_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(rs_data_b),
        .rs_busy_o(rs_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(rs_data_n),
        .rs_busy_o(rs_busy_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic [31:0] nd0;
        logic [31:0] nd1;
        logic [1:0]  nb;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1, input logic ie,
                         input logic [4:0] ia, input logic fl, input logic [4:0] ra0,
                         input logic [4:0] ra1);
        wr_en      = we;
        wr_addr    = {wa1, wa0};
        wr_data    = {wd1, wd0};
        issue_en   = ie;
        issue_addr = ia;
        flush      = fl;
        rs_addr    = {ra1, ra0};
    endtask

    initial begin
        //                we     wa0 wd0           wa1 wd1           ie ia fl ra0 ra1  ed0           ed1           eb     nd0           nd1           nb
        vecs[0]  = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 5,  0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
        vecs[1]  = '{2'b11, 0,  32'h1234,     7,  32'hABCD,     0, 0, 0, 0,  7,  32'h0,        32'hABCD,     2'b00, 32'h0,        32'h0,        2'b00};
        vecs[2]  = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 0,  7,  32'h0,        32'hABCD,     2'b00, 32'h0,        32'hABCD,     2'b00};
        vecs[3]  = '{2'b11, 3,  32'h11,       3,  32'h22,       0, 0, 0, 3,  3,  32'h22,       32'h22,       2'b00, 32'h0,        32'h0,        2'b00};
        vecs[4]  = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 3,  7,  32'h22,       32'hABCD,     2'b00, 32'h22,       32'hABCD,     2'b00};
        vecs[5]  = '{2'b01, 9,  32'h55,       0,  32'h0,        0, 0, 0, 9,  9,  32'h55,       32'h55,       2'b00, 32'h0,        32'h0,        2'b00};
        vecs[6]  = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 9,  9,  32'h55,       32'h55,       2'b00, 32'h55,       32'h55,       2'b00};
        vecs[7]  = '{2'b00, 0,  32'h0,        0,  32'h0,        1, 4, 0, 4,  4,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
        vecs[8]  = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 4,  4,  32'h0,        32'h0,        2'b11, 32'h0,        32'h0,        2'b11};
        vecs[9]  = '{2'b10, 0,  32'h0,        4,  32'h44,       0, 0, 0, 4,  4,  32'h44,       32'h44,       2'b00, 32'h0,        32'h0,        2'b11};
        vecs[10] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 4,  4,  32'h44,       32'h44,       2'b00, 32'h44,       32'h44,       2'b00};
        vecs[11] = '{2'b01, 4,  32'h45,       0,  32'h0,        1, 4, 0, 4,  4,  32'h45,       32'h45,       2'b00, 32'h44,       32'h44,       2'b00};
        vecs[12] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 4,  4,  32'h45,       32'h45,       2'b11, 32'h45,       32'h45,       2'b11};
        vecs[13] = '{2'b00, 0,  32'h0,        0,  32'h0,        1, 2, 0, 2,  6,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
        vecs[14] = '{2'b00, 0,  32'h0,        0,  32'h0,        1, 6, 0, 2,  6,  32'h0,        32'h0,        2'b01, 32'h0,        32'h0,        2'b01};
        vecs[15] = '{2'b00, 0,  32'h0,        0,  32'h0,        1, 31,0, 6,  31, 32'h0,        32'h0,        2'b01, 32'h0,        32'h0,        2'b01};
        vecs[16] = '{2'b01, 6,  32'h77,       0,  32'h0,        1, 8, 1, 31, 6,  32'h0,        32'h77,       2'b01, 32'h0,        32'h0,        2'b11};
        vecs[17] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 8,  6,  32'h0,        32'h77,       2'b00, 32'h0,        32'h77,       2'b00};
        vecs[18] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 2,  31, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
        vecs[19] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 4,  31, 32'h45,       32'h0,        2'b00, 32'h45,       32'h0,        2'b00};
        vecs[20] = '{2'b11, 12, 32'h12,       0,  32'h99,       1, 0, 0, 0,  12, 32'h0,        32'h12,       2'b00, 32'h0,        32'h0,        2'b00};
        vecs[21] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 0,  12, 32'h0,        32'h12,       2'b00, 32'h0,        32'h12,       2'b00};
        vecs[22] = '{2'b11, 10, 32'hA0,       11, 32'hB0,       0, 0, 0, 10, 11, 32'hA0,       32'hB0,       2'b00, 32'h0,        32'h0,        2'b00};
        vecs[23] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 10, 11, 32'hA0,       32'hB0,       2'b00, 32'hA0,       32'hB0,       2'b00};
        vecs[24] = '{2'b11, 13, 32'hC0,       0,  32'hEE,       0, 0, 0, 13, 0,  32'hC0,       32'h0,        2'b00, 32'h0,        32'h0,        2'b00};
        vecs[25] = '{2'b00, 0,  32'h0,        0,  32'h0,        0, 0, 0, 13, 0,  32'hC0,       32'h0,        2'b00, 32'hC0,       32'h0,        2'b00};

        rst_n = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        #3;
        chk("reset byp d0", rs_data_b[31:0], 32'h0);
        chk("reset byp busy", {30'h0, rs_busy_b}, 32'h0);
        chk("reset nb d1", rs_data_n[63:32], 32'h0);
        #8 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].ie, vecs[i].ia, vecs[i].fl, vecs[i].ra0, vecs[i].ra1);
            @(negedge clk);
            chk($sformatf("v%0d byp d0", i), rs_data_b[31:0],  vecs[i].ed0);
            chk($sformatf("v%0d byp d1", i), rs_data_b[63:32], vecs[i].ed1);
            chk($sformatf("v%0d byp busy", i), {30'h0, rs_busy_b}, {30'h0, vecs[i].eb});
            chk($sformatf("v%0d nb d0", i), rs_data_n[31:0],  vecs[i].nd0);
            chk($sformatf("v%0d nb d1", i), rs_data_n[63:32], vecs[i].nd1);
            chk($sformatf("v%0d nb busy", i), {30'h0, rs_busy_n}, {30'h0, vecs[i].nb});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges with a write to x5 in flight.
        drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5, 0, 5, 4);
        @(posedge clk);
        #1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 4);
        #2;
        chk("pre-reset nb x5", rs_data_n[31:0], 32'hDEADBEEF);
        chk("pre-reset byp x5 busy", {31'h0, rs_busy_b[0]}, 32'h1);
        drive(2'b01, 5, 32'h1111, 0, 0, 0, 0, 0, 5, 4);
        rst_n = 1'b0;
        #1;
        chk("mid-reset byp x5", rs_data_b[31:0], 32'h0);
        chk("mid-reset byp x4", rs_data_b[63:32], 32'h0);
        chk("mid-reset byp busy", {30'h0, rs_busy_b}, 32'h0);
        chk("mid-reset nb x5", rs_data_n[31:0], 32'h0);
        chk("mid-reset nb busy", {30'h0, rs_busy_n}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 4);
        #1;
        chk("post-reset nb x5", rs_data_n[31:0], 32'h0);
        chk("post-reset nb x4", rs_data_n[63:32], 32'h0);
        chk("post-reset busy", {30'h0, rs_busy_b}, 32'h0);

        // First edge after reset release commits writes and issues.
        drive(2'b01, 5, 32'h5, 0, 0, 1, 4, 0, 5, 4);
        @(posedge clk);
        #1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 4);
        #1;
        chk("first-edge nb x5", rs_data_n[31:0], 32'h5);
        chk("first-edge nb busy", {30'h0, rs_busy_n}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
